axi_uartlite_resp: RTL

AXI_UARTLITE_RESP -- requirements
Module: axi_uartlite_resp

---
 rtl/axi_uartlite_resp.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_uartlite_resp.sv
// AXI4-lite UART-lite register front end: TX/RX byte FIFOs, status and control registers.
// Byte streams on tx_*/rx_* connect to the serializer; this block owns only the bus side.
module axi_uartlite_resp #(
   parameter int unsigned DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [3:0]  s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] A_RX   = 2'd0;
   localparam logic [1:0] A_TX   = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;
   localparam logic [1:0] A_CTRL = 2'd3;

   logic          aw_held, w_held, overrun;
   logic [1:0]    aw_addr_q;
   logic [7:0]    w_byte_q;
   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
   logic [CW-1:0] tx_cnt, rx_cnt;

   logic          aw_hs, w_hs, ar_hs, exec;
   logic [1:0]    wr_addr, rd_addr;
   logic [7:0]    wr_byte, tx_head_nxt;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
   logic [AW-1:0] tx_wr_nxt, tx_rd_nxt, rx_wr_nxt, rx_rd_nxt;
   logic [CW-1:0] tx_cnt_nxt, rx_cnt_nxt;
   logic          aw_held_nxt, w_held_nxt, bvalid_nxt, rvalid_nxt, overrun_nxt;
   logic [31:0]   stat, rdata_nxt;
   logic [1:0]    rresp_nxt;
   logic          unused;

   assign unused = ^{s_axi_wstrb, s_axi_wdata[31:8], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Next-state for bus channels and both FIFOs
   always_comb begin
      aw_hs    = s_axi_awvalid & s_axi_awready;
      w_hs     = s_axi_wvalid & s_axi_wready;
      ar_hs    = s_axi_arvalid & s_axi_arready;
      exec     = (aw_held | aw_hs) & (w_held | w_hs);
      wr_addr  = aw_held ? aw_addr_q : s_axi_awaddr[3:2];
      wr_byte  = w_held ? w_byte_q : s_axi_wdata[7:0];
      rd_addr  = s_axi_araddr[3:2];

      tx_full  = (tx_cnt == CW'(DEPTH));
      tx_empty = (tx_cnt == '0);
      rx_full  = (rx_cnt == CW'(DEPTH));
      rx_empty = (rx_cnt == '0);

      tx_push  = exec & (wr_addr == A_TX) & ~tx_full;
      tx_pop   = tx_valid & tx_ready;
      tx_flush = exec & (wr_addr == A_CTRL) & wr_byte[0];
      rx_push  = rx_valid & ~rx_full;
      rx_pop   = ar_hs & (rd_addr == A_RX) & ~rx_empty;
      rx_flush = exec & (wr_addr == A_CTRL) & wr_byte[1];

      tx_wr_nxt  = tx_flush ? '0 : tx_wr + AW'(tx_push);
      tx_rd_nxt  = tx_flush ? '0 : tx_rd + AW'(tx_pop);
      tx_cnt_nxt = tx_flush ? '0 : tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_wr_nxt  = rx_flush ? '0 : rx_wr + AW'(rx_push);
      rx_rd_nxt  = rx_flush ? '0 : rx_rd + AW'(rx_pop);
      rx_cnt_nxt = rx_flush ? '0 : rx_cnt + CW'(rx_push) - CW'(rx_pop);

      // Head after this edge is the byte being written when it lands on the new read slot
      tx_head_nxt = (tx_push && (tx_wr == tx_rd_nxt)) ? wr_byte : tx_mem[tx_rd_nxt];

      aw_held_nxt = exec ? 1'b0 : (aw_held | aw_hs);
      w_held_nxt  = exec ? 1'b0 : (w_held | w_hs);
      bvalid_nxt  = exec | (s_axi_bvalid & ~s_axi_bready);
      rvalid_nxt  = ar_hs | (s_axi_rvalid & ~s_axi_rready);
      overrun_nxt = (rx_valid & rx_full) | (overrun & ~(ar_hs & (rd_addr == A_STAT)));

      stat = {26'd0, overrun, 1'b0, tx_full, tx_empty, rx_full, ~rx_empty};

      rdata_nxt = '0;
      rresp_nxt = RESP_OKAY;
      case (rd_addr)
         A_RX:    rdata_nxt = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd]};
         A_STAT:  rdata_nxt = stat;
         default: rresp_nxt = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr_q     <= '0;
         w_byte_q      <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_arready <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_rvalid  <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
         tx_valid      <= 1'b0;
         tx_data       <= '0;
         overrun       <= 1'b0;
         tx_wr         <= '0;
         tx_rd         <= '0;
         tx_cnt        <= '0;
         rx_wr         <= '0;
         rx_rd         <= '0;
         rx_cnt        <= '0;
      end else begin
         aw_held       <= aw_held_nxt;
         w_held        <= w_held_nxt;
         if (aw_hs) aw_addr_q <= s_axi_awaddr[3:2];
         if (w_hs)  w_byte_q  <= s_axi_wdata[7:0];
         s_axi_awready <= ~aw_held_nxt & ~bvalid_nxt;
         s_axi_wready  <= ~w_held_nxt & ~bvalid_nxt;
         s_axi_arready <= ~rvalid_nxt;
         s_axi_bvalid  <= bvalid_nxt;
         if (exec)
            s_axi_bresp <= ((wr_addr == A_RX) || (wr_addr == A_STAT)) ? RESP_SLVERR : RESP_OKAY;
         s_axi_rvalid  <= rvalid_nxt;
         if (ar_hs) begin
            s_axi_rdata <= rdata_nxt;
            s_axi_rresp <= rresp_nxt;
         end
         tx_valid      <= (tx_cnt_nxt != '0);
         tx_data       <= tx_head_nxt;
         overrun       <= overrun_nxt;
         tx_wr         <= tx_wr_nxt;
         tx_rd         <= tx_rd_nxt;
         tx_cnt        <= tx_cnt_nxt;
         rx_wr         <= rx_wr_nxt;
         rx_rd         <= rx_rd_nxt;
         rx_cnt        <= rx_cnt_nxt;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the counters
   always_ff @(posedge clk) begin
      if (!rst && tx_push && !tx_flush) tx_mem[tx_wr] <= wr_byte;
      if (!rst && rx_push && !rx_flush) rx_mem[rx_wr] <= rx_data;
   end
endmodule
